regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_sb_if.sv | 41 ++++
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_sb.sv | 84 ++++++++
 tb/tb_regfile_sb.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and the hard-wired zero register.
package regfile_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int R0_ADDR        = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/reserve bus of the scoreboarded register file; slave side is the register file itself.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] regSource1;
  logic [ADDR_WIDTH-1:0] regSource2;
  logic [DATA_WIDTH-1:0] data1;
  logic [DATA_WIDTH-1:0] data2;
  logic                  busy1;
  logic                  busy2;
  logic                  writeEnableA;
  logic [ADDR_WIDTH-1:0] regDestinationA;
  logic [DATA_WIDTH-1:0] writeDataA;
  logic                  writeEnableB;
  logic [ADDR_WIDTH-1:0] regDestinationB;
  logic [DATA_WIDTH-1:0] writeDataB;
  logic                  reserveEnable;
  logic [ADDR_WIDTH-1:0] regReserve;
  logic [ADDR_WIDTH:0]   pendingCount;

  modport slave (
    input  regSource1, regSource2,
    input  writeEnableA, regDestinationA, writeDataA,
    input  writeEnableB, regDestinationB, writeDataB,
    input  reserveEnable, regReserve,
    output data1, data2, busy1, busy2, pendingCount
  );

  modport master (
    output regSource1, regSource2,
    output writeEnableA, regDestinationA, writeDataA,
    output writeEnableB, regDestinationB, writeDataB,
    output reserveEnable, regReserve,
    input  data1, data2, busy1, busy2, pendingCount
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: writes clear, reserves set (reserve wins on collision), registered population count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       we_a,
  input  logic [ADDR_WIDTH-1:0]      dest_a,
  input  logic                       we_b,
  input  logic [ADDR_WIDTH-1:0]      dest_b,
  input  logic                       rsv_en,
  input  logic [ADDR_WIDTH-1:0]      rsv_addr,
  output logic [(2**ADDR_WIDTH)-1:0] pending,
  output logic [ADDR_WIDTH:0]        pending_count
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(R0_ADDR);

  logic [DEPTH-1:0]    pend_next;
  logic [ADDR_WIDTH:0] count_next;

  always_comb begin
    pend_next = pending;
    if (we_a && dest_a != R0)
      pend_next[dest_a] = 1'b0;
    if (we_b && dest_b != R0)
      pend_next[dest_b] = 1'b0;
    if (rsv_en && rsv_addr != R0)
      pend_next[rsv_addr] = 1'b1;
    pend_next[R0_ADDR] = 1'b0;
  end

  // Count the next-state vector so the count lands on the same edge as the bits.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++)
      count_next = count_next + (ADDR_WIDTH+1)'(pend_next[i]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pend_next;
      pending_count <= count_next;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write/two-read register file with reserve scoreboard; R0 reads zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and reserve status) to the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] R0 = ADDR_WIDTH'(R0_ADDR);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      pending;

  regfile_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clock         (clock),
    .reset         (reset),
    .we_a          (bus.writeEnableA),
    .dest_a        (bus.regDestinationA),
    .we_b          (bus.writeEnableB),
    .dest_b        (bus.regDestinationB),
    .rsv_en        (bus.reserveEnable),
    .rsv_addr      (bus.regReserve),
    .pending       (pending),
    .pending_count (bus.pendingCount)
  );

  // Port B is applied last so it wins a same-register collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else begin
      if (bus.writeEnableA && bus.regDestinationA != R0)
        regs[bus.regDestinationA] <= bus.writeDataA;
      if (bus.writeEnableB && bus.regDestinationB != R0)
        regs[bus.regDestinationB] <= bus.writeDataB;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd_data(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] d;
    if (addr == R0)
      d = '0;
`ifdef REGFILE_BYPASS_EN
    else if (bus.writeEnableB && bus.regDestinationB == addr)
      d = bus.writeDataB;
    else if (bus.writeEnableA && bus.regDestinationA == addr)
      d = bus.writeDataA;
`endif
    else
      d = regs[addr];
    return d;
  endfunction

  function automatic logic rd_busy(input logic [ADDR_WIDTH-1:0] addr);
    logic b;
    if (addr == R0)
      b = 1'b0;
`ifdef REGFILE_BYPASS_EN
    else if (bus.reserveEnable && bus.regReserve == addr)
      b = 1'b1;
    else if ((bus.writeEnableA && bus.regDestinationA == addr) ||
             (bus.writeEnableB && bus.regDestinationB == addr))
      b = 1'b0;
`endif
    else
      b = pending[addr];
    return b;
  endfunction

  always_comb begin
    bus.data1 = rd_data(bus.regSource1);
    bus.data2 = rd_data(bus.regSource2);
    bus.busy1 = rd_busy(bus.regSource1);
    bus.busy2 = rd_busy(bus.regSource2);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed, table-driven bench for regfile_sb plus hand sequences for collisions and async reset.
module tb_regfile_sb;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  regfile_sb_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        we_a;
    logic [2:0]  dst_a;
    logic [15:0] wd_a;
    logic        we_b;
    logic [2:0]  dst_b;
    logic [15:0] wd_b;
    logic        rsv;
    logic [2:0]  rsv_addr;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.writeEnableA    = 1'b0;
    bus.regDestinationA = '0;
    bus.writeDataA      = '0;
    bus.writeEnableB    = 1'b0;
    bus.regDestinationB = '0;
    bus.writeDataB      = '0;
    bus.reserveEnable   = 1'b0;
    bus.regReserve      = '0;
  endtask

  task automatic check_reads(input string name, input logic [15:0] d1, input logic [15:0] d2,
                             input logic b1, input logic b2, input logic [3:0] cnt);
    check({name, ".data1"}, 32'(bus.data1), 32'(d1));
    check({name, ".data2"}, 32'(bus.data2), 32'(d2));
    check({name, ".busy1"}, 32'(bus.busy1), 32'(b1));
    check({name, ".busy2"}, 32'(bus.busy2), 32'(b2));
    check({name, ".count"}, 32'(bus.pendingCount), 32'(cnt));
  endtask

  function automatic vec_t mk(input string name,
                              input logic we_a, input logic [2:0] dst_a, input logic [15:0] wd_a,
                              input logic we_b, input logic [2:0] dst_b, input logic [15:0] wd_b,
                              input logic rsv, input logic [2:0] rsv_addr,
                              input logic [2:0] rs1, input logic [2:0] rs2,
                              input logic [15:0] e_d1, input logic [15:0] e_d2,
                              input logic e_b1, input logic e_b2, input logic [3:0] e_cnt);
    vec_t v;
    v.name = name; v.we_a = we_a; v.dst_a = dst_a; v.wd_a = wd_a;
    v.we_b = we_b; v.dst_b = dst_b; v.wd_b = wd_b; v.rsv = rsv; v.rsv_addr = rsv_addr;
    v.rs1 = rs1; v.rs2 = rs2; v.e_d1 = e_d1; v.e_d2 = e_d2;
    v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_cnt = e_cnt;
    return v;
  endfunction

  logic [3:0] rsv_loop_cnt [1:7];

  initial begin
    idle_inputs();
    bus.regSource1 = '0;
    bus.regSource2 = '0;

    //           name        weA dA  wdA      weB dB  wdB      rsv rA  rs1 rs2 d1       d2       b1 b2 cnt
    vecs.push_back(mk("wrA_r2",   1, 2, 16'h23FE, 0, 0, 16'h0000, 0, 0, 2, 0, 16'h23FE, 16'h0000, 0, 0, 0));
    vecs.push_back(mk("ab_r4",    1, 4, 16'h1111, 1, 4, 16'h6781, 0, 0, 4, 2, 16'h6781, 16'h23FE, 0, 0, 0));
    vecs.push_back(mk("r0_ign",   0, 0, 16'h0000, 1, 0, 16'hFFFF, 1, 0, 0, 4, 16'h0000, 16'h6781, 0, 0, 0));
    vecs.push_back(mk("rsv_r3",   0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 3, 5, 16'h0000, 16'h0000, 1, 0, 1));
    vecs.push_back(mk("rsv_r5",   0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 3, 5, 16'h0000, 16'h0000, 1, 1, 2));
    vecs.push_back(mk("rsv_r3b",  0, 0, 16'h0000, 0, 0, 16'h0000, 1, 3, 3, 5, 16'h0000, 16'h0000, 1, 1, 2));
    vecs.push_back(mk("wrA_r3",   1, 3, 16'h00AA, 0, 0, 16'h0000, 0, 0, 3, 5, 16'h00AA, 16'h0000, 0, 1, 1));
    vecs.push_back(mk("ab_dist",  1, 1, 16'h0F0F, 1, 7, 16'hBEEF, 0, 0, 1, 7, 16'h0F0F, 16'hBEEF, 0, 0, 1));
    vecs.push_back(mk("wrB_r5",   0, 0, 16'h0000, 1, 5, 16'h5555, 0, 0, 5, 3, 16'h5555, 16'h00AA, 0, 0, 0));
    vecs.push_back(mk("wrA_np",   1, 5, 16'h7777, 0, 0, 16'h0000, 0, 0, 5, 2, 16'h7777, 16'h23FE, 0, 0, 0));
    vecs.push_back(mk("wrA_r6",   1, 6, 16'h0BAD, 0, 0, 16'h0000, 0, 0, 6, 1, 16'h0BAD, 16'h0F0F, 0, 0, 0));

    rsv_loop_cnt[1] = 4'd2; rsv_loop_cnt[2] = 4'd3; rsv_loop_cnt[3] = 4'd4; rsv_loop_cnt[4] = 4'd5;
    rsv_loop_cnt[5] = 4'd6; rsv_loop_cnt[6] = 4'd6; rsv_loop_cnt[7] = 4'd7;

    // Reset held through a couple of edges, then released between edges.
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    for (int a = 0; a < 8; a++) begin
      bus.regSource1 = 3'(a);
      bus.regSource2 = 3'(7 - a);
      #1 check_reads($sformatf("reset_r%0d", a), 16'h0, 16'h0, 0, 0, 0);
    end

    foreach (vecs[i]) begin
      @(negedge clock);
      bus.writeEnableA = vecs[i].we_a; bus.regDestinationA = vecs[i].dst_a; bus.writeDataA = vecs[i].wd_a;
      bus.writeEnableB = vecs[i].we_b; bus.regDestinationB = vecs[i].dst_b; bus.writeDataB = vecs[i].wd_b;
      bus.reserveEnable = vecs[i].rsv; bus.regReserve = vecs[i].rsv_addr;
      @(posedge clock);
      #1 idle_inputs();
      bus.regSource1 = vecs[i].rs1;
      bus.regSource2 = vecs[i].rs2;
      #1 check_reads(vecs[i].name, vecs[i].e_d1, vecs[i].e_d2, vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_cnt);
    end

    // Reserve and write R6 in the same cycle: observe the read before and after the edge.
    @(negedge clock);
    bus.regSource1 = 3'd6;
    bus.regSource2 = 3'd0;
    bus.reserveEnable = 1'b1; bus.regReserve = 3'd6;
    bus.writeEnableA = 1'b1; bus.regDestinationA = 3'd6; bus.writeDataA = 16'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    check_reads("r6_during", 16'h1234, 16'h0, 1, 0, 0);
`else
    check_reads("r6_during", 16'h0BAD, 16'h0, 0, 0, 0);
`endif
    @(posedge clock);
    #1 idle_inputs();
    #1 check_reads("r6_after", 16'h1234, 16'h0, 1, 0, 1);

    // Reserve every register in turn; R6 is already pending, count tops out at 7.
    for (int r = 1; r < 8; r++) begin
      @(negedge clock);
      bus.reserveEnable = 1'b1; bus.regReserve = 3'(r);
      @(posedge clock);
      #1 idle_inputs();
      bus.regSource1 = 3'(r);
      bus.regSource2 = 3'd0;
      #1 check_reads($sformatf("rsv_all_r%0d", r), (r == 6) ? 16'h1234 : (r == 2) ? 16'h23FE :
                     (r == 1) ? 16'h0F0F : (r == 3) ? 16'h00AA : (r == 4) ? 16'h6781 :
                     (r == 5) ? 16'h7777 : 16'hBEEF, 16'h0, 1, 0, rsv_loop_cnt[r]);
    end

    // Async reset between edges with R1/R2 pending: state must clear before the next posedge.
    @(posedge clock);
    #2 reset = 1'b0;
    bus.writeEnableA = 1'b1; bus.regDestinationA = 3'd2; bus.writeDataA = 16'h9999;
    bus.reserveEnable = 1'b1; bus.regReserve = 3'd2;
    bus.regSource1 = 3'd1;
    bus.regSource2 = 3'd2;
    #1 check_reads("async_rst", 16'h0, 16'h0, 0, 0, 0);
    for (int a = 3; a < 8; a++) begin
      bus.regSource1 = 3'(a);
      #1 check(($sformatf("async_rst_r%0d", a)), 32'(bus.data1), 32'h0);
    end
    bus.regSource1 = 3'd1;
    @(posedge clock);
    #1 check_reads("in_rst_discard", 16'h0, 16'h0, 0, 0, 0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1 check_reads("post_rst_idle", 16'h0, 16'h0, 0, 0, 0);

    @(negedge clock);
    bus.writeEnableB = 1'b1; bus.regDestinationB = 3'd2; bus.writeDataB = 16'h4242;
    bus.reserveEnable = 1'b1; bus.regReserve = 3'd1;
    @(posedge clock);
    #1 idle_inputs();
    #1 check_reads("post_rst_wr", 16'h0, 16'h4242, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
